// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Writer side of a configuration flip-flop chain that programs routing-mux
//   SRAM bits. Bitstream words arrive on a valid/ready stream and are
//   serialised MSB-first onto ccff_head. ccff_shift_en qualifies each bit.
//   While the new bits go in, the bits that fall out of ccff_tail are folded
//   into a running parity of the chain's previous contents. Completion is
//   flagged after exactly CHAIN_LEN bits. Low bits of the last word that do
//   not fit are discarded.
//
// Parameters
//   CHAIN_LEN  number of configuration bits in the chain (>= 1)
//   WORD_W     input word width (>= 1)
//   CNT_W      bit counter width, derived from CHAIN_LEN
//
// Ports
//   prog_clk       programming clock, the only clock
//   pReset         synchronous active-high reset
//   start          single-cycle load request; only acted on in IDLE or DONE
//   in_valid       in_data holds a valid word
//   in_data        bitstream word; bit WORD_W-1 goes out first
//   in_ready       high in LOAD; a word is taken when in_valid && in_ready
//   ccff_head      registered serial data into the chain
//   ccff_shift_en  registered; the chain captures ccff_head when high
//   ccff_tail      serial data from the chain's last flop
//   busy           high in LOAD or SHIFT
//   config_done    high in DONE
//   tail_parity    XOR of ccff_tail over every shift edge of this load
//   bit_count      bits committed to the chain in this load
module ccff_chain_loader #(
  parameter int  CHAIN_LEN = 6,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              config_done,
  output logic              tail_parity,
  output logic [CNT_W-1:0]  bit_count
);

  // Remaining-bits counter for the word being shifted; holds 0..WORD_W.
  localparam int REM_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               head_d;
  logic               shift_en_d;
  logic               parity_d;
  logic [CNT_W-1:0]   count_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               chain_full;
  logic               word_last;

  // The bit presented in this SHIFT cycle is the last one of the whole
  // chain; this wins over the word boundary so surplus word bits drop out.
  assign chain_full = (bit_count == CNT_W'(CHAIN_LEN - 1));
  // The bit presented in this SHIFT cycle is the word's final bit.
  assign word_last  = (rem_q == REM_W'(1));

  assign in_ready    = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign config_done = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    head_d     = ccff_head;
    shift_en_d = ccff_shift_en;
    parity_d   = tail_parity;
    count_d    = bit_count;
    rem_d      = rem_q;
    word_d     = word_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_LOAD;
          count_d  = '0;
          parity_d = 1'b0;
          rem_d    = '0;
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          // MSB goes straight to the head; the rest is kept left-aligned
          // so the next bit out is always word_q[WORD_W-1].
          head_d     = in_data[WORD_W-1];
          word_d     = in_data << 1;
          shift_en_d = 1'b1;
          rem_d      = REM_W'(WORD_W);
          state_d    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        count_d  = bit_count + 1'b1;
        parity_d = tail_parity ^ ccff_tail;
        if (word_last || chain_full) begin
          head_d     = 1'b0;
          shift_en_d = 1'b0;
          rem_d      = '0;
          state_d    = chain_full ? ST_DONE : ST_LOAD;
        end else begin
          head_d = word_q[WORD_W-1];
          word_d = word_q << 1;
          rem_d  = rem_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and registered outputs
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q       <= ST_IDLE;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      tail_parity   <= 1'b0;
      bit_count     <= '0;
      rem_q         <= '0;
    end else begin
      state_q       <= state_d;
      ccff_head     <= head_d;
      ccff_shift_en <= shift_en_d;
      tail_parity   <= parity_d;
      bit_count     <= count_d;
      rem_q         <= rem_d;
    end
  end

  // Word shift register; only read in SHIFT after a fresh capture
  always_ff @(posedge prog_clk) begin
    word_q <= word_d;
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;       // 0: 6-bit chain instance, 1: 20-bit chain instance
  logic       start_d;
  logic       valid_d;
  logic [7:0] data_d;

  logic       s6, v6, r6, h6, e6, t6, b6, dn6, p6;
  logic [2:0] c6;
  logic       s20, v20, r20, h20, e20, t20, b20, dn20, p20;
  logic [4:0] c20;

  assign s6  = start_d & ~sel;
  assign v6  = valid_d & ~sel;
  assign s20 = start_d & sel;
  assign v20 = valid_d & sel;

  ccff_chain_loader #(.CHAIN_LEN(6), .WORD_W(8)) u_dut6 (
    .prog_clk(clk), .pReset(rst), .start(s6), .in_valid(v6), .in_data(data_d),
    .in_ready(r6), .ccff_head(h6), .ccff_shift_en(e6), .ccff_tail(t6),
    .busy(b6), .config_done(dn6), .tail_parity(p6), .bit_count(c6));

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
    .prog_clk(clk), .pReset(rst), .start(s20), .in_valid(v20), .in_data(data_d),
    .in_ready(r20), .ccff_head(h20), .ccff_shift_en(e20), .ccff_tail(t20),
    .busy(b20), .config_done(dn20), .tail_parity(p20), .bit_count(c20));

  // Behavioural model of the configuration chains themselves.
  logic [5:0]  chain6, pre6_val;
  logic [19:0] chain20, pre20_val;
  logic        pre_en;
  always @(posedge clk) begin
    if (pre_en) chain6 <= pre6_val;
    else if (e6) chain6 <= {chain6[4:0], h6};
  end
  always @(posedge clk) begin
    if (pre_en) chain20 <= pre20_val;
    else if (e20) chain20 <= {chain20[18:0], h20};
  end
  assign t6  = chain6[5];
  assign t20 = chain20[19];

  logic       o_head, o_sen, o_ready, o_busy, o_done, o_par;
  logic [4:0] o_cnt;
  assign o_head  = sel ? h20  : h6;
  assign o_sen   = sel ? e20  : e6;
  assign o_ready = sel ? r20  : r6;
  assign o_busy  = sel ? b20  : b6;
  assign o_done  = sel ? dn20 : dn6;
  assign o_par   = sel ? p20  : p6;
  assign o_cnt   = sel ? c20  : {2'b00, c6};

  int vectors = 0;
  int miscompares = 0;

  task automatic preload(input logic [5:0] v6i, input logic [19:0] v20i);
    pre6_val = v6i; pre20_val = v20i; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Full load on the selected instance, checked against a stream model:
  // the chain must end up holding the first CHAIN_LEN bits of the words,
  // MSB first, and the parity must equal the XOR of the old chain contents.
  task automatic run_load(input bit big, input int nwords, input logic [7:0] w0,
                          input logic [7:0] w1, input logic [7:0] w2,
                          input int gap_fixed, input bit start_noise);
    int len, exp_words, nobs, accepts, cyc, run, wi, gap_left, rem, bad_cnt, bad_head, bad_ovl;
    logic [7:0] words[3];
    logic [31:0] exp_stream, obs, chain_now;
    logic exp_par;
    bit done_seen, prev_sen, runs_ok;
    int runs[$];
    len = big ? 20 : 6;
    words[0] = w0; words[1] = w1; words[2] = w2;
    exp_stream = '0;
    for (int i = 0; i < len; i++) exp_stream = {exp_stream[30:0], words[i/8][7 - (i%8)]};
    exp_words = (len + 7) / 8;
    exp_par = big ? ^chain20 : ^chain6;
    sel = big;
    start_d = 1'b1; valid_d = 1'b0;
    @(negedge clk);
    start_d = 1'b0;
    vectors++;
    if ({o_ready, o_busy, o_done, o_sen, o_par} !== 5'b11000 || o_cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL start_to_load: rdy/busy/done/sen/par=%b cnt=%0d required 11000 cnt=0",
               {o_ready, o_busy, o_done, o_sen, o_par}, o_cnt);
    end
    nobs = 0; accepts = 0; cyc = 0; run = 0; wi = 0; obs = '0;
    bad_cnt = 0; bad_head = 0; bad_ovl = 0; done_seen = 0; prev_sen = 0;
    gap_left = (gap_fixed >= 0) ? gap_fixed : $urandom_range(0, 3);
    while (!done_seen && cyc < 400) begin
      if (o_done) begin
        done_seen = 1;
        if (run > 0) runs.push_back(run);
        vectors++;
        if (!prev_sen) begin
          miscompares++;
          $display("FAIL done_timing: config_done rose %0d cycles late, required right after last shift", 1);
        end
      end else if (o_sen) begin
        obs = {obs[30:0], o_head}; nobs++; run++;
        if (o_ready || !o_busy) bad_ovl++;
      end else begin
        if (run > 0) runs.push_back(run);
        run = 0;
        if (o_head !== 1'b0) bad_head++;
      end
      if (o_ready && int'(o_cnt) != nobs) bad_cnt++;
      if (int'(o_cnt) > len) bad_cnt++;
      prev_sen = o_sen;
      if (!done_seen) begin
        start_d = start_noise && o_sen;
        if (o_ready) begin
          if (gap_left > 0) begin
            valid_d = 1'b0; data_d = 8'($urandom); gap_left--;
          end else begin
            valid_d = 1'b1;
            data_d = (wi < nwords) ? words[wi] : 8'($urandom);
            wi++; accepts++;
            gap_left = (gap_fixed >= 0) ? gap_fixed : $urandom_range(0, 3);
          end
        end else begin
          valid_d = 1'($urandom_range(0, 1)); data_d = 8'($urandom);
        end
        cyc++;
        @(negedge clk);
      end
    end
    start_d = 1'b0; valid_d = 1'b0;
    vectors++;
    if (!done_seen) begin
      miscompares++;
      $display("FAIL load_timeout: no config_done after %0d cycles, required within 400", cyc);
    end
    vectors++;
    if (nobs != len || obs !== exp_stream) begin
      miscompares++;
      $display("FAIL head_stream: got %0d bits %h, required %0d bits %h", nobs, obs, len, exp_stream);
    end
    runs_ok = (runs.size() == exp_words);
    rem = len;
    for (int i = 0; i < runs.size() && runs_ok; i++) begin
      if (runs[i] != ((rem > 8) ? 8 : rem)) runs_ok = 0;
      rem -= runs[i];
    end
    vectors++;
    if (!runs_ok) begin
      miscompares++;
      $display("FAIL shift_runs: got %0d runs (first %0d), required %0d runs of min(8,left)",
               runs.size(), (runs.size() > 0) ? runs[0] : -1, exp_words);
    end
    vectors++;
    if (accepts != exp_words) begin
      miscompares++;
      $display("FAIL words_taken: got %0d, required %0d", accepts, exp_words);
    end
    vectors++;
    if (bad_cnt != 0 || bad_head != 0 || bad_ovl != 0) begin
      miscompares++;
      $display("FAIL cycle_rules: cnt_err=%0d head_err=%0d sen_err=%0d, required 0/0/0", bad_cnt, bad_head, bad_ovl);
    end
    chain_now = big ? {12'd0, chain20} : {26'd0, chain6};
    vectors++;
    if (chain_now !== exp_stream) begin
      miscompares++;
      $display("FAIL chain_contents: got %h, required %h", chain_now, exp_stream);
    end
    vectors++;
    if (o_par !== exp_par || int'(o_cnt) != len) begin
      miscompares++;
      $display("FAIL final_state: parity=%b cnt=%0d, required parity=%b cnt=%0d", o_par, o_cnt, exp_par, len);
    end
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({o_done, o_busy, o_ready, o_sen} !== 4'b1000 || int'(o_cnt) != len) begin
      miscompares++;
      $display("FAIL done_hold: done/busy/rdy/sen=%b cnt=%0d, required 1000 cnt=%0d",
               {o_done, o_busy, o_ready, o_sen}, o_cnt, len);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; start_d = 1'b0; valid_d = 1'b0; data_d = '0; pre_en = 1'b0;
    @(negedge clk);
    preload(6'($urandom), 20'($urandom));
    rst = 1'b0;
    vectors++;
    if ({h6, e6, p6, c6, dn6, b6, r6} !== 9'd0 || {h20, e20, p20, c20, dn20, b20, r20} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: dut6=%b dut20=%b, required all 0",
               {h6, e6, p6, c6, dn6, b6, r6}, {h20, e20, p20, c20, dn20, b20, r20});
    end
  endtask

  task automatic test_single_word();
    run_load(0, 1, 8'hB4, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic test_long_chain();
    run_load(1, 3, 8'hFF, 8'h00, 8'hA5, 0, 0);
  endtask

  task automatic test_backpressure();
    run_load(0, 1, 8'($urandom), 8'h00, 8'h00, 5, 0);
    run_load(1, 3, 8'($urandom), 8'($urandom), 8'($urandom), 5, 0);
  endtask

  task automatic test_tail_parity();
    preload(6'b111000, 20'($urandom));
    run_load(0, 1, 8'($urandom), 8'h00, 8'h00, 0, 0);
    vectors++;
    if (p6 !== 1'b1) begin
      miscompares++;
      $display("FAIL tail_parity_111000: got %b, required 1", p6);
    end
    sel = 1'b0; start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    vectors++;
    if (p6 !== 1'b0 || dn6 !== 1'b0 || r6 !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clears: parity=%b done=%b rdy=%b, required 0 0 1", p6, dn6, r6);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen, cyc;
    run_load(0, 1, 8'($urandom), 8'h00, 8'h00, 0, 0);
    sel = 1'b0; start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0; valid_d = 1'b1; data_d = 8'($urandom);
    seen = 0; cyc = 0;
    while (seen < 3 && cyc < 50) begin
      @(negedge clk);
      valid_d = 1'b0;
      if (e6) seen++;
      cyc++;
    end
    vectors++;
    if (seen < 3) begin
      miscompares++;
      $display("FAIL reach_third_shift: saw %0d shift cycles, required 3", seen);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({h6, e6, p6, c6, dn6, b6, r6} !== 9'd0) begin
      miscompares++;
      $display("FAIL abort_reset: outputs=%b, required all 0", {h6, e6, p6, c6, dn6, b6, r6});
    end
    run_load(0, 1, 8'($urandom), 8'h00, 8'h00, -1, 0);
  endtask

  task automatic test_start_ignored();
    run_load(0, 1, 8'($urandom), 8'h00, 8'h00, 0, 1);
    run_load(1, 3, 8'($urandom), 8'($urandom), 8'($urandom), -1, 1);
  endtask

  task automatic test_done_restart();
    run_load(1, 3, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
    sel = 1'b1; start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    vectors++;
    if (dn20 !== 1'b0 || r20 !== 1'b1 || c20 !== 5'd0) begin
      miscompares++;
      $display("FAIL done_restart: done=%b rdy=%b cnt=%0d, required 0 1 0", dn20, r20, c20);
    end
    run_load(1, 3, 8'($urandom), 8'($urandom), 8'($urandom), -1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      run_load(1'($urandom_range(0, 1)), 3, 8'($urandom), 8'($urandom), 8'($urandom),
               -1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_long_chain();
    test_backpressure();
    test_tail_parity();
    test_reset_mid_shift();
    test_start_ignored();
    test_done_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Writer side of the configuration chain that programs routing-mux SRAM bits (sram/sram_inv of mux_tree_tapbuf cells) on the programming clock.
- Accepts bitstream words over a valid/ready stream and serialises them MSB-first onto ccff_head with a qualifying shift enable.
- Monitors ccff_tail during shifting, so that the previous chain contents are checked as a running parity.
- Signals completion after exactly CHAIN_LEN bits.

Parameters:
- CHAIN_LEN, 6, number of configuration bits in the chain; must be >= 1.
- WORD_W, 8, input word width; must be >= 1.
- CNT_W, clog2(CHAIN_LEN+1), width of the bit counter; derived, never overridden.

Ports:
- prog_clk  input  1  programming clock; the only clock.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  input  1  in_data holds a valid word.
- in_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- in_ready  output  1  word accepted on an edge where in_valid && in_ready.
- ccff_head  output  1  serial data into the chain; registered.
- ccff_shift_en  output  1  chain captures ccff_head on every prog_clk edge where this is 1; registered.
- ccff_tail  input  1  serial data out of the chain's last flop.
- busy  output  1  high in LOAD or SHIFT.
- config_done  output  1  high in DONE.
- tail_parity  output  1  XOR of ccff_tail over all shift edges of the current load.
- bit_count  output  CNT_W  number of bits committed in the current load.

Behaviour:
- Reset:
  - pReset sampled high forces IDLE on that edge.
  - All registered outputs go to 0: ccff_head, ccff_shift_en, tail_parity, bit_count; config_done and busy are 0 because state is IDLE.
  - Reset mid-SHIFT aborts the load; the partial chain contents are left as-is.
  - pReset has priority over every other input.
- States: IDLE, LOAD, SHIFT, DONE. in_ready is combinational and equals (state==LOAD).
- IDLE or DONE:
  - start=1 moves to LOAD next cycle.
  - On that same edge, bit_count, tail_parity and the word-bit index are cleared.
  - In DONE, config_done holds until start or pReset.
- LOAD:
  - in_valid=0: stay in LOAD; shift_en=0.
  - On an accept edge: capture the word; ccff_head <= in_data[WORD_W-1]; ccff_shift_en <= 1; state <= SHIFT.
  - The number of bits taken from this word is n = min(WORD_W, CHAIN_LEN - bit_count).
- SHIFT:
  - Each cycle in SHIFT has ccff_shift_en=1 and presents one bit.
  - Edge actions, every shift edge:
    - bit_count += 1.
    - tail_parity ^= ccff_tail.
    - If more bits of the word remain, ccff_head <= the next lower bit.
    - Otherwise ccff_shift_en <= 0 and ccff_head <= 0, and state <= DONE if bit_count+1 == CHAIN_LEN, else LOAD.
  - Unused low bits of the final word are discarded.
- Timing:
  - A word occupies n SHIFT cycles plus at least one LOAD cycle, so back-to-back throughput is n+1 cycles per word.
  - config_done rises in the cycle after the last shift_en=1 cycle.
- start outside IDLE/DONE is ignored. in_valid outside LOAD is ignored; no word is consumed.
- bit_count never exceeds CHAIN_LEN, and ccff_shift_en is never 1 outside SHIFT.

Test Plan:
- CHAIN_LEN=6, WORD_W=8. start, then word 0xB4 with in_valid held -> in_ready for 1 cycle; ccff_head = 1,0,1,1,0,1 on 6 consecutive shift_en cycles; config_done=1 the next cycle; bit_count=6; bits 0,0 are dropped.
- CHAIN_LEN=20, WORD_W=8. Words 0xFF, 0x00, 0xA5 -> shift_en runs of 8, 8 and 4 cycles separated by single LOAD cycles; last 4 head bits are 1,0,1,0; done when bit_count=20.
- Backpressure: in_valid=0 for 5 cycles in LOAD -> in_ready stays 1, shift_en stays 0, bit_count is unchanged; shifting resumes on the accept edge.
- Tail parity: CHAIN_LEN=6, ccff_tail driven 1,1,1,0,0,0 during the shift cycles -> tail_parity=1. A second start clears it to 0.
- pReset on the 3rd shift cycle -> next cycle all outputs 0, state IDLE; a subsequent start and full load completes normally with bit_count=CHAIN_LEN.
- start pulsed during SHIFT -> no effect. start in DONE -> config_done drops and in_ready rises the next cycle.
